// File: rtl/mips_pkg.sv
// Shared MIPS definitions: load/store opcodes and the memory-stage FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request port: req/ack handshake with word address, byte enables and data.
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for stores, load extraction with sign/zero extension, misalignment check.
// MEM_STAGE_MISALIGN_TRAP_EN enables the misalignment flag; otherwise it is tied low.
module mem_align
    import mips_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  a,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic        is_mem,
    output logic        is_load,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misalign
);
    logic               is_byte, is_half, is_word;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_sx, half_sx;

    assign byte_s  = rdata[{a, 3'b000} +: 8];
    assign half_s  = rdata[{a[1], 4'b0000} +: 16];
    assign byte_sx = byte_s;
    assign half_sx = half_s;

    always_comb begin
        is_byte = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
        is_half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        is_word = (op == OP_LW) || (op == OP_SW);
        is_load = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                  (op == OP_LBU) || (op == OP_LHU);
        is_mem  = is_byte || is_half || is_word;

        be    = 4'b0000;
        wdata = st_data;
        if (is_byte) begin
            be    = 4'b0001 << a;
            wdata = {4{st_data[7:0]}};
        end else if (is_half) begin
            be    = a[1] ? 4'b1100 : 4'b0011;
            wdata = {2{st_data[15:0]}};
        end else if (is_word) begin
            be    = 4'b1111;
        end

        unique case (op)
            OP_LB:   ld_data = byte_sx;
            OP_LBU:  ld_data = {24'd0, byte_s};
            OP_LH:   ld_data = half_sx;
            OP_LHU:  ld_data = {16'd0, half_s};
            default: ld_data = rdata;
        endcase
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misalign = (is_half && a[0]) || (is_word && (a != 2'b00));
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: one data-memory request per load/store, registered result to write-back.
// MEM_STAGE_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into addr_err results.
module mem_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        Ins,
    input  logic [31:0]        Result,
    input  logic [31:0]        Rdata2,
    mem_stage_if.master        mem,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [31:0]        out_ins,
    output logic               addr_err
);
    state_t            state, next_state;
    logic              accept, go_req, in_req;
    logic [5:0]        al_op;
    logic [1:0]        al_a;
    logic              is_mem, is_load, misalign;
    logic [3:0]        be;
    logic [31:0]       wdata, ld_data;

    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_be_r;
    logic [31:0]       mem_wdata_r;
    logic [31:0]       out_data_r, out_ins_r;
    logic              addr_err_r;

    // In REQ the held instruction and its address (parked in out_data) drive load extraction
    assign in_req = (state == REQ);
    assign al_op  = in_req ? out_ins_r[31:26] : Ins[31:26];
    assign al_a   = in_req ? out_data_r[1:0]  : Result[1:0];

    mem_align u_align (
        .op       (al_op),
        .a        (al_a),
        .st_data  (Rdata2),
        .rdata    (mem.mem_rdata),
        .is_mem   (is_mem),
        .is_load  (is_load),
        .be       (be),
        .wdata    (wdata),
        .ld_data  (ld_data),
        .misalign (misalign)
    );

    assign in_ready = RST && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign go_req   = is_mem && !misalign;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept)
                    next_state = go_req ? REQ : DONE;
                else if ((state == DONE) && out_ready)
                    next_state = IDLE;
            end
            REQ:     if (mem.mem_ack) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'd0;
            out_data_r  <= 32'd0;
            out_ins_r   <= 32'd0;
            addr_err_r  <= 1'b0;
        end else if (accept) begin
            out_data_r <= Result;
            out_ins_r  <= Ins;
            addr_err_r <= misalign;
            if (go_req) begin
                mem_we_r    <= !is_load;
                mem_addr_r  <= {Result[ADDR_W-1:2], 2'b00};
                mem_be_r    <= be;
                mem_wdata_r <= wdata;
            end
        end else if (in_req && mem.mem_ack && is_load) begin
            out_data_r <= ld_data;
        end
    end

    assign mem.mem_req   = in_req;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_be    = mem_be_r;
    assign mem.mem_wdata = mem_wdata_r;

    assign out_valid = (state == DONE);
    assign out_data  = out_data_r;
    assign out_ins   = out_ins_r;
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a result scoreboard popped on each write-back handshake.
module tb_mem_stage;
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] ins;
        logic        err;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready;
    logic [31:0] Ins, Result, Rdata2;
    logic        out_valid, out_ready;
    logic [31:0] out_data, out_ins;
    logic        addr_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mem_stage_if #(.ADDR_W(32)) mif ();

    mem_stage #(.ADDR_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ins       (Ins),
        .Result    (Result),
        .Rdata2    (Rdata2),
        .mem       (mif),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ins   (out_ins),
        .addr_err  (addr_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every write-back handshake must match the oldest expected result
    always @(negedge CLK) begin
        if (RST && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed result %h expected none", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", out_data, e.data);
                chk("sb_ins", out_ins, e.ins);
                chk("sb_err", 32'(addr_err), 32'(e.err));
            end
        end
    end

    task automatic mem_op(input logic [31:0] ins, input logic [31:0] res,
                          input logic [31:0] rd2, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int stall);
        logic st;
        st       = (ins[31:29] == 3'b101);
        in_valid = 1'b1;
        Ins      = ins;
        Result   = res;
        Rdata2   = rd2;
        sb.push_back('{exp_data, ins, 1'b0});
        cyc();
        in_valid = 1'b0;
        for (int c = 0; c <= stall; c++) begin
            chk("req", 32'(mif.mem_req), 32'd1);
            chk("addr", mif.mem_addr, {res[31:2], 2'b00});
            chk("be", 32'(mif.mem_be), 32'(exp_be));
            chk("we", 32'(mif.mem_we), 32'(st));
            if (st) chk("wdata", mif.mem_wdata, exp_wdata);
            chk("in_ready_req", 32'(in_ready), 32'd0);
            chk("out_valid_req", 32'(out_valid), 32'd0);
            if (c == stall) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = rdata;
            end
            cyc();
        end
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'd0;
        chk("out_valid_done", 32'(out_valid), 32'd1);
        chk("req_done", 32'(mif.mem_req), 32'd0);
        chk("out_data_done", out_data, exp_data);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST           = 1'b0;
        in_valid      = 1'b0;
        Ins           = 32'd0;
        Result        = 32'd0;
        Rdata2        = 32'd0;
        out_ready     = 1'b1;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_req", 32'(mif.mem_req), 32'd0);
        chk("rst_we", 32'(mif.mem_we), 32'd0);
        chk("rst_addr", mif.mem_addr, 32'd0);
        chk("rst_be", 32'(mif.mem_be), 32'd0);
        chk("rst_wdata", mif.mem_wdata, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ins", out_ins, 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        RST = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        cyc();

        // SW with three request cycles, then loads at the upper lanes
        mem_op({6'h2B, 26'h0432000}, 32'h100, 32'hDEADBEEF, 32'h0, 32'h100, 4'b1111, 32'hDEADBEEF, 2);
        mem_op({6'h20, 26'h0411000}, 32'h103, 32'h0, 32'h80112233, 32'hFFFFFF80, 4'b1000, 32'h0, 0);
        mem_op({6'h24, 26'h0411000}, 32'h103, 32'h0, 32'h80112233, 32'h00000080, 4'b1000, 32'h0, 1);
        mem_op({6'h21, 26'h0412000}, 32'h102, 32'h0, 32'h80011234, 32'hFFFF8001, 4'b1100, 32'h0, 0);
        mem_op({6'h25, 26'h0412000}, 32'h102, 32'h0, 32'h80011234, 32'h00008001, 4'b1100, 32'h0, 0);
        mem_op({6'h28, 26'h0413000}, 32'h102, 32'h123456A5, 32'h0, 32'h102, 4'b0100, 32'hA5A5A5A5, 0);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        in_valid = 1'b1;
        Ins      = {6'h29, 26'h0414000};
        Result   = 32'h101;
        Rdata2   = 32'h0000CAFE;
        sb.push_back('{32'h101, {6'h29, 26'h0414000}, 1'b1});
        cyc();
        in_valid = 1'b0;
        chk("trap_req", 32'(mif.mem_req), 32'd0);
        chk("trap_out_valid", 32'(out_valid), 32'd1);
        chk("trap_addr_err", 32'(addr_err), 32'd1);
        chk("trap_out_data", out_data, 32'h101);
        cyc();
`else
        mem_op({6'h29, 26'h0414000}, 32'h101, 32'h0000CAFE, 32'h0, 32'h101, 4'b0011, 32'hCAFECAFE, 0);
`endif

        // Back-to-back pass-through at full rate
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            Ins      = {6'h00, 5'd1, 5'd2, 5'(i + 3), 5'd0, 6'h20};
            Result   = 32'h1000 + 32'(i);
            sb.push_back('{32'h1000 + 32'(i), {6'h00, 5'd1, 5'd2, 5'(i + 3), 5'd0, 6'h20}, 1'b0});
            cyc();
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_data", out_data, 32'h1000 + 32'(i));
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // Write-back stall holds the result and blocks the next accept
        in_valid = 1'b1;
        Ins      = 32'h00A41820;
        Result   = 32'h55;
        sb.push_back('{32'h55, 32'h00A41820, 1'b0});
        cyc();
        Ins       = 32'h00C72020;
        Result    = 32'h66;
        out_ready = 1'b0;
        sb.push_back('{32'h66, 32'h00C72020, 1'b0});
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, 32'h55);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            if (i < 2) cyc();
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("after_hold_data", out_data, 32'h66);
        cyc();

        // Reset while a request is outstanding
        in_valid = 1'b1;
        Ins      = {6'h23, 26'h0415000};
        Result   = 32'h200;
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_req", 32'(mif.mem_req), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("async_req", 32'(mif.mem_req), 32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        cyc();
        RST = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_req", 32'(mif.mem_req), 32'd0);
        mem_op({6'h23, 26'h0416000}, 32'h300, 32'h0, 32'h12345678, 32'h12345678, 4'b1111, 32'h0, 0);

        repeat (2) cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIPS pipeline, directly downstream of the EX stage. Takes EX's `Result` as effective address (or pass-through value), `Rdata2` as store data and the instruction word. Issues one request per load/store to a data-memory port with a req/ack handshake, steers byte lanes, sign/zero-extends loads, and presents a registered result to write-back with a valid/ready handshake.

## Interface

- `ADDR_W`, 32: memory address width; `mem_addr` is `Result[ADDR_W-1:0]` with bits [1:0] cleared.
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  EX presents an instruction.
- `in_ready`  out  1  stage accepts on `in_valid && in_ready` at a `CLK` edge.
- `Ins`  in  32  instruction word; `Ins[31:26]` selects the access type.
- `Result`  in  32  EX ALU result: address for loads/stores, value otherwise.
- `Rdata2`  in  32  store data (rt).
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  1 for store.
- `mem_addr`  out  ADDR_W  word-aligned address.
- `mem_be`  out  4  byte enables, bit i = byte lane i (little-endian).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory completes the request this cycle.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.
- `out_valid`  out  1  result available to write-back.
- `out_ready`  in  1  write-back consumes the result.
- `out_data`  out  32  load data, or `Result` for all other instructions.
- `out_ins`  out  32  instruction word carried alongside `out_data`.
- `addr_err`  out  1  misaligned-access flag, qualified by `out_valid`.

## Operation

- Decoded opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Every other opcode is a pass-through.
- FSM states:
  - IDLE: `in_ready`=1. On accept, a load/store goes to REQ; a pass-through or misaligned access captures output and goes to DONE.
  - REQ: `mem_req`=1 with `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` stable. On `mem_ack`, capture formatted data and go to DONE.
  - DONE: `out_valid`=1 and outputs held stable. On `out_ready`, go to IDLE, or accept a new instruction in the same edge if `in_valid` is high.
- `in_ready` = IDLE, or (DONE && `out_ready`). `in_ready` is 0 in REQ.
- `mem_ack` is sampled only in REQ and ignored in all other states.
- Store lanes, with `a = Result[1:0]`:
  - SB: `be = 1<<a`, `wdata = {4{Rdata2[7:0]}}`.
  - SH: `be = a[1] ? 4'b1100 : 4'b0011`, `wdata = {2{Rdata2[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = Rdata2`.
- Loads: byte taken from `mem_rdata[8a+7:8a]`; halfword taken from `mem_rdata[16a[1]+15:16a[1]]`. LB/LH sign-extend; LBU/LHU zero-extend. For loads, `mem_be` shows the lanes read.
- Stores drive `out_data = Result`. Write-back ignores it based on `out_ins`.

## Timing

- Reset (RST low, asynchronous): state IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `out_valid`, `out_data`, `out_ins`, `addr_err` all 0; `in_ready` forced 0 while RST is low.
- Pass-through: accepted at edge k, `out_valid` from edge k+1. Throughput is 1/cycle when `out_ready` stays high.
- Memory access: accepted at edge k; `mem_req` high from edge k+1. `mem_ack` in that first REQ cycle gives `out_valid` from edge k+2, so minimum latency is 2. Each stall cycle adds 1.
- `out_ready` low in DONE holds all outputs; no new accept occurs.
- Reset in REQ: the request is abandoned and `mem_req` drops asynchronously. Memory must tolerate the dropped request.

## Configuration

- Macro: `MEM_STAGE_MISALIGN_TRAP_EN`.
- Defined:
  - LH/LHU/SH with `a[0]`=1, or LW/SW with `a`≠0, issue no memory request.
  - The stage goes straight to DONE with `addr_err=1` and `out_data=Result` (bad vaddr).
- Undefined:
  - Misaligned low bits are ignored: the halfword lane uses `a[1]`; a word uses lanes 3:0.
  - `addr_err` is tied to 0.

## Structure

- Shared package `mips_pkg` holds:
  - the opcode localparams for the eight load/store instructions;
  - the FSM state typedef (IDLE/REQ/DONE).
- One combinational sub-module, `mem_align`, performs store lane steering (`be`/`wdata`), load extraction with sign/zero extension, and the misalignment check.
- The FSM and registers stay in `mem_stage`.

## Test plan

- SW, `Result`=0x100, `Rdata2`=0xDEADBEEF, `mem_ack` after 3 REQ cycles -> `mem_req` high 3 cycles with `mem_addr`=0x100, `be`=1111, `wdata`=DEADBEEF; `out_valid` the cycle after ack.
- LB at 0x103, `mem_rdata`=0x80112233 -> `out_data`=0xFFFFFF80; LBU at 0x103 -> 0x00000080.
- LH at 0x102, `mem_rdata`=0x80011234 -> `out_data`=0xFFFF8001, `be`=1100; LHU at 0x102 -> 0x00008001.
- SH at 0x101:
  - with macro -> no `mem_req`, `addr_err`=1, `out_data`=0x101;
  - without macro -> `mem_addr`=0x100, `be`=0011, `addr_err`=0.
- Back-to-back ADD instructions with `out_ready`=1 -> one result per cycle, `out_data`=`Result`. Then `out_ready` low 2 cycles -> `out_valid`/`out_data` held and `in_ready`=0.
- RST low during REQ -> `mem_req` and `out_valid` go to 0 immediately. After release, `in_ready`=1 and a following LW of 0x12345678 completes with `out_data`=0x12345678.
